// File: rtl/tms_seq_pkg.sv
// tms_seq_pkg: shared constants and FSM state type for the stimulation pulse
// sequencer (tms_pulse_sequencer and its us_tick_gen prescaler).
package tms_seq_pkg;

   localparam int unsigned CLK_PER_US = 50;  // sys_clk cycles per microsecond
   localparam int unsigned N_CH       = 5;   // IGBT channels
   localparam int unsigned US_W       = 24;  // microsecond timer / config width
   localparam int unsigned PCNT_W     = 8;   // pulse-in-burst counter width
   localparam int unsigned BCNT_W     = 16;  // burst-in-train counter width

   typedef enum logic [2:0] {
      S_IDLE,
      S_PULSE_ON,
      S_PULSE_GAP,
      S_BURST_GAP,
      S_DONE
   } state_e;

endpackage

// File: rtl/tms_pulse_sequencer_us_tick.sv
// us_tick_gen: free-running microsecond prescaler.
//   sys_clk / sys_rst : clock, synchronous active-high reset
//   clr               : synchronous clear of the count (restarts the us phase)
//   tick              : high on the last cycle (count CLK_PER_US-1) of each us
module us_tick_gen #(
   parameter int unsigned CLK_PER_US = 50
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_US - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/tms_pulse_sequencer.sv
// tms_pulse_sequencer: generates pulse trains (pulses -> bursts -> train) on a
// 1 us timebase, driving per-channel IGBT enables for the programmed width.
//   start / stop        : start request (IDLE only) / abort request
//   ch_sel, pulse_*, burst_*, *_per_* : train configuration, latched at start
//   igbt_on_en          : latched ch_sel while a pulse is on, else 0
//   igbt_on_time        : latched pulse width (held until next accepted start)
//   busy / done / aborted / cfg_err : status and one-cycle strobes
//   pulse_idx / burst_idx : position within the train
// All outputs are registered from next-state values.
module tms_pulse_sequencer #(
   parameter int unsigned CLK_PER_US = tms_seq_pkg::CLK_PER_US,
   parameter int unsigned N_CH       = tms_seq_pkg::N_CH
) (
   input  logic                              sys_clk,
   input  logic                              sys_rst,
   input  logic                              start,
   input  logic                              stop,
   input  logic [N_CH-1:0]                   ch_sel,
   input  logic [tms_seq_pkg::US_W-1:0]      pulse_width_us,
   input  logic [tms_seq_pkg::US_W-1:0]      pulse_period_us,
   input  logic [tms_seq_pkg::PCNT_W-1:0]    pulses_per_burst,
   input  logic [tms_seq_pkg::US_W-1:0]      burst_period_us,
   input  logic [tms_seq_pkg::BCNT_W-1:0]    bursts_per_train,
   output logic [N_CH-1:0]                   igbt_on_en,
   output logic [tms_seq_pkg::US_W-1:0]      igbt_on_time,
   output logic                              busy,
   output logic                              done,
   output logic                              aborted,
   output logic                              cfg_err,
   output logic [tms_seq_pkg::PCNT_W-1:0]    pulse_idx,
   output logic [tms_seq_pkg::BCNT_W-1:0]    burst_idx
);
   import tms_seq_pkg::*;

   state_e              state_q, state_d;
   logic [N_CH-1:0]     ch_q, ch_d;
   logic [US_W-1:0]     width_q, width_d;
   logic [US_W-1:0]     period_q, period_d;
   logic [US_W-1:0]     bperiod_q, bperiod_d;
   logic [PCNT_W-1:0]   ppb_q, ppb_d;
   logic [BCNT_W-1:0]   bpt_q, bpt_d;
   logic [PCNT_W-1:0]   pidx_q, pidx_d;
   logic [BCNT_W-1:0]   bidx_q, bidx_d;
   logic [US_W-1:0]     ptmr_q, ptmr_d;
   logic [US_W-1:0]     btmr_q, btmr_d;
   logic [N_CH-1:0]     en_q, en_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                aborted_q, aborted_d;
   logic                cfg_err_q, cfg_err_d;

   logic                tick;
   logic                presc_clr;
   logic                cfg_ok;
   logic                last_pulse;
   logic                last_burst;
   logic [31:0]         burst_span;
   logic [US_W-1:0]     ptmr_inc;
   logic [US_W-1:0]     btmr_inc;

   us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .clr     (presc_clr),
      .tick    (tick)
   );

   always_comb begin
      burst_span = 32'(pulses_per_burst) * 32'(pulse_period_us);
      cfg_ok = (pulse_width_us != '0) &&
               (pulse_width_us < pulse_period_us) &&
               (pulses_per_burst != '0) &&
               (bursts_per_train != '0) &&
               (ch_sel != '0) &&
               !((bursts_per_train > BCNT_W'(1)) && (burst_span > 32'(burst_period_us)));

      // saturating "value after this tick"
      ptmr_inc   = (ptmr_q == '1) ? ptmr_q : ptmr_q + US_W'(1);
      btmr_inc   = (btmr_q == '1) ? btmr_q : btmr_q + US_W'(1);
      last_pulse = (pidx_q == ppb_q - PCNT_W'(1));
      last_burst = (bidx_q == bpt_q - BCNT_W'(1));
   end

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      width_d   = width_q;
      period_d  = period_q;
      bperiod_d = bperiod_q;
      ppb_d     = ppb_q;
      bpt_d     = bpt_q;
      pidx_d    = pidx_q;
      bidx_d    = bidx_q;
      ptmr_d    = ptmr_q;
      btmr_d    = btmr_q;
      aborted_d = 1'b0;
      cfg_err_d = 1'b0;
      presc_clr = 1'b0;

      if ((state_q != S_IDLE) && tick) begin
         ptmr_d = ptmr_inc;
         btmr_d = btmr_inc;
      end

      unique case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               if (cfg_ok) begin
                  ch_d      = ch_sel;
                  width_d   = pulse_width_us;
                  period_d  = pulse_period_us;
                  bperiod_d = burst_period_us;
                  ppb_d     = pulses_per_burst;
                  bpt_d     = bursts_per_train;
                  pidx_d    = '0;
                  bidx_d    = '0;
                  ptmr_d    = '0;
                  btmr_d    = '0;
                  presc_clr = 1'b1;
                  state_d   = S_PULSE_ON;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         S_PULSE_ON: begin
            if (tick && (ptmr_inc == width_q)) begin
               state_d = (last_pulse && last_burst) ? S_DONE : S_PULSE_GAP;
            end
         end
         S_PULSE_GAP: begin
            if (tick && (ptmr_inc == period_q)) begin
               if (!last_pulse) begin
                  pidx_d  = pidx_q + PCNT_W'(1);
                  ptmr_d  = '0;
                  state_d = S_PULSE_ON;
               end else if (!last_burst) begin
                  // burst fully packed (span == burst period): the burst gap
                  // has zero length, so start the next burst on this tick
                  if (btmr_inc == bperiod_q) begin
                     bidx_d  = bidx_q + BCNT_W'(1);
                     pidx_d  = '0;
                     ptmr_d  = '0;
                     btmr_d  = '0;
                     state_d = S_PULSE_ON;
                  end else begin
                     state_d = S_BURST_GAP;
                  end
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_BURST_GAP: begin
            if (tick && (btmr_inc == bperiod_q)) begin
               bidx_d  = bidx_q + BCNT_W'(1);
               pidx_d  = '0;
               ptmr_d  = '0;
               btmr_d  = '0;
               state_d = S_PULSE_ON;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (stop && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         aborted_d = 1'b1;
      end

      en_d   = (state_d == S_PULSE_ON) ? ch_d : '0;
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q   <= S_IDLE;
         ch_q      <= '0;
         width_q   <= '0;
         period_q  <= '0;
         bperiod_q <= '0;
         ppb_q     <= '0;
         bpt_q     <= '0;
         pidx_q    <= '0;
         bidx_q    <= '0;
         ptmr_q    <= '0;
         btmr_q    <= '0;
         en_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         width_q   <= width_d;
         period_q  <= period_d;
         bperiod_q <= bperiod_d;
         ppb_q     <= ppb_d;
         bpt_q     <= bpt_d;
         pidx_q    <= pidx_d;
         bidx_q    <= bidx_d;
         ptmr_q    <= ptmr_d;
         btmr_q    <= btmr_d;
         en_q      <= en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign igbt_on_en   = en_q;
   assign igbt_on_time = width_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign aborted      = aborted_q;
   assign cfg_err      = cfg_err_q;
   assign pulse_idx    = pidx_q;
   assign burst_idx    = bidx_q;

endmodule

// File: tb/tb_tms_pulse_sequencer.sv
// tb_tms_pulse_sequencer: checks tms_pulse_sequencer against a reference model
// that derives every output from the pulse-train schedule arithmetic
// (pulse k of burst j starts at 50*(j*burst_period + k*pulse_period) cycles).
module tb_tms_pulse_sequencer;

   localparam int unsigned CPU = 50;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        start   = 1'b0;
   logic        stop    = 1'b0;
   logic [4:0]  ch_sel  = '0;
   logic [23:0] pulse_width_us   = '0;
   logic [23:0] pulse_period_us  = '0;
   logic [7:0]  pulses_per_burst = '0;
   logic [23:0] burst_period_us  = '0;
   logic [15:0] bursts_per_train = '0;

   logic [4:0]  igbt_on_en;
   logic [23:0] igbt_on_time;
   logic        busy, done, aborted, cfg_err;
   logic [7:0]  pulse_idx;
   logic [15:0] burst_idx;

   tms_pulse_sequencer #(.CLK_PER_US(50), .N_CH(5)) dut (
      .sys_clk          (sys_clk),
      .sys_rst          (sys_rst),
      .start            (start),
      .stop             (stop),
      .ch_sel           (ch_sel),
      .pulse_width_us   (pulse_width_us),
      .pulse_period_us  (pulse_period_us),
      .pulses_per_burst (pulses_per_burst),
      .burst_period_us  (burst_period_us),
      .bursts_per_train (bursts_per_train),
      .igbt_on_en       (igbt_on_en),
      .igbt_on_time     (igbt_on_time),
      .busy             (busy),
      .done             (done),
      .aborted          (aborted),
      .cfg_err          (cfg_err),
      .pulse_idx        (pulse_idx),
      .burst_idx        (burst_idx)
   );

   always #5 sys_clk = ~sys_clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // reference model state
   bit          m_act = 0;
   int unsigned m_n = 0;          // cycles since accepting edge (1 = first)
   int unsigned m_done_n = 0;
   int unsigned m_w, m_pp, m_p, m_bp, m_b;
   logic [4:0]  m_ch = '0;
   logic [23:0] m_on = '0;
   int unsigned m_pidx = 0, m_bidx = 0;
   bit          m_abort = 0, m_cerr = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic bit cfg_valid();
      int unsigned w, pp, p, bp, b;
      w = pulse_width_us; pp = pulse_period_us; p = pulses_per_burst;
      bp = burst_period_us; b = bursts_per_train;
      if (w == 0 || w >= pp || p == 0 || b == 0 || ch_sel == 0) return 0;
      if (b > 1 && p * pp > bp) return 0;
      return 1;
   endfunction

   // true when cycle offset m (0 = first train cycle) lies inside any pulse
   function automatic bit in_pulse(input int unsigned m);
      for (int unsigned j = 0; j < m_b; j++)
         for (int unsigned k = 0; k < m_p; k++) begin
            int unsigned s;
            s = CPU * (j * m_bp + k * m_pp);
            if (m >= s && m < s + CPU * m_w) return 1;
         end
      return 0;
   endfunction

   // update the model for one rising edge, given the inputs presented to it
   task automatic model_edge(input bit s, input bit p, input bit r);
      m_abort = 0;
      m_cerr  = 0;
      if (r) begin
         m_act = 0; m_on = '0; m_pidx = 0; m_bidx = 0;
         return;
      end
      if (m_act) begin
         if (p) begin
            m_act = 0; m_abort = 1;
         end else if (m_n == m_done_n) begin
            m_act = 0;
         end else begin
            m_n++;
         end
      end else if (s && !p) begin
         if (cfg_valid()) begin
            m_w = pulse_width_us; m_pp = pulse_period_us; m_p = pulses_per_burst;
            m_bp = burst_period_us; m_b = bursts_per_train; m_ch = ch_sel;
            m_on = pulse_width_us;
            m_act = 1; m_n = 1;
            m_done_n = 1 + CPU * ((m_b - 1) * m_bp + (m_p - 1) * m_pp + m_w);
         end else begin
            m_cerr = 1;
         end
      end
      if (m_act) begin
         // most recent pulse start at or before this cycle
         for (int unsigned j = 0; j < m_b; j++)
            for (int unsigned k = 0; k < m_p; k++)
               if (CPU * (j * m_bp + k * m_pp) <= m_n - 1) begin
                  m_bidx = j; m_pidx = k;
               end
      end
   endtask

   task automatic compare();
      logic [4:0]  e_en;
      logic        e_busy, e_done;
      e_en   = (m_act && in_pulse(m_n - 1)) ? m_ch : 5'd0;
      e_busy = m_act;
      e_done = m_act && (m_n == m_done_n);
      check("ctl{en,busy,done,abort,cfg_err}",
            64'({igbt_on_en, busy, done, aborted, cfg_err}),
            64'({e_en, e_busy, e_done, m_abort, m_cerr}));
      check("idx{pulse,burst,on_time}",
            64'({pulse_idx, burst_idx, igbt_on_time}),
            64'({m_pidx[7:0], m_bidx[15:0], m_on}));
   endtask

   task automatic cyc(input bit s, input bit p, input bit r);
      start = s; stop = p; sys_rst = r;
      @(posedge sys_clk);
      model_edge(s, p, r);
      @(negedge sys_clk);
      compare();
   endtask

   task automatic set_cfg(input int unsigned w, input int unsigned pp, input int unsigned p,
                          input int unsigned bp, input int unsigned b, input logic [4:0] ch);
      pulse_width_us = 24'(w); pulse_period_us = 24'(pp); pulses_per_burst = 8'(p);
      burst_period_us = 24'(bp); bursts_per_train = 16'(b); ch_sel = ch;
   endtask

   // start a train and clock it to completion; optional stop/reset at a
   // given cycle offset, optional start held high and config scrambled
   task automatic run_train(input int stop_at, input int rst_at,
                            input bit hold_start, input bit scramble);
      int unsigned guard = 0;
      cyc(1, 0, 0);
      while (m_act && guard < 20000) begin
         guard++;
         if (scramble) begin
            set_cfg($urandom, $urandom, $urandom, $urandom, $urandom, 5'($urandom));
         end
         if (int'(m_n) == stop_at) cyc(hold_start, 1, 0);
         else if (int'(m_n) == rst_at) cyc(0, 0, 1);
         else cyc(hold_start, 0, 0);
      end
      check("train_bound", 64'(m_act), 64'(0));
      repeat (3) cyc(0, 0, 0);
   endtask

   initial begin
      repeat (3) cyc(0, 0, 1);

      // four 150-cycle pulses, single burst
      set_cfg(3, 10, 4, 0, 1, 5'b00001);
      run_train(-1, -1, 0, 0);

      // three bursts of two pulses
      set_cfg(2, 5, 2, 20, 3, 5'b10101);
      run_train(-1, -1, 0, 0);

      // fully packed bursts: zero-length burst gap
      set_cfg(1, 2, 3, 6, 2, 5'b01010);
      run_train(-1, -1, 0, 0);

      // rejected configurations
      set_cfg(10, 10, 2, 0, 1, 5'b00001);
      cyc(1, 0, 0); repeat (2) cyc(0, 0, 0);
      set_cfg(1, 10, 3, 25, 2, 5'b00001);
      cyc(1, 0, 0); repeat (2) cyc(0, 0, 0);
      set_cfg(1, 3, 2, 10, 1, 5'b00000);
      cyc(1, 0, 0); repeat (2) cyc(0, 0, 0);

      // stop in the middle of the second pulse, then restart
      set_cfg(3, 10, 4, 0, 1, 5'b00001);
      run_train(1 + CPU * 10 + 20, -1, 0, 0);
      run_train(-1, -1, 0, 0);

      // reset in the burst gap
      set_cfg(2, 5, 2, 20, 3, 5'b10101);
      run_train(-1, 1 + CPU * 12, 0, 0);

      // start held high for the whole train is ignored
      set_cfg(3, 10, 4, 0, 1, 5'b11001);
      run_train(-1, -1, 1, 0);

      // start and stop together in IDLE
      set_cfg(2, 5, 2, 20, 3, 5'b10101);
      cyc(1, 1, 0); repeat (3) cyc(0, 0, 0);

      // randomized trains
      for (int i = 0; i < 16; i++) begin
         int sa, ra;
         set_cfg($urandom_range(1, 4), $urandom_range(1, 6), $urandom_range(0, 4),
                 $urandom_range(0, 24), $urandom_range(0, 3), 5'($urandom));
         sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 600)) : -1;
         ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 600)) : -1;
         run_train(sa, ra, bit'($urandom_range(0, 1)), 1);
         if ($urandom_range(0, 3) == 0) begin
            set_cfg(1, 2, 1, 0, 1, 5'b00001);
            cyc(1, 1, 0); cyc(0, 0, 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tms_pulse_sequencer.md
# tms_pulse_sequencer

Upstream timing source for the IGBT/SCR driver stage. Generates stimulation pulse trains (pulses grouped into bursts, bursts grouped into a train) by asserting per-channel IGBT enables for a programmed width on a 1 µs timebase. It also presents the latched on-time to the driver. Configuration is captured at start; the block runs autonomously until the train completes or is stopped.

## Interface
- CLK_PER_US, 50: sys_clk cycles per µs (50 MHz clock).
- N_CH, 5: number of IGBT channels.
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- stop  in  1  abort request; honoured in any state.
- ch_sel  in  N_CH  channels to fire; latched at start.
- pulse_width_us  in  24  IGBT on-time per pulse, µs.
- pulse_period_us  in  24  pulse start-to-start spacing within a burst, µs.
- pulses_per_burst  in  8  pulses in each burst.
- burst_period_us  in  24  burst start-to-start spacing, µs.
- bursts_per_train  in  16  bursts in the train.
- igbt_on_en  out  N_CH  enables to driver; equals latched ch_sel during a pulse, else 0.
- igbt_on_time  out  24  latched pulse_width_us; held after completion until next accepted start.
- busy  out  1  high from first pulse cycle through DONE.
- done  out  1  one-cycle completion strobe.
- aborted  out  1  one-cycle strobe on stop while busy.
- cfg_err  out  1  one-cycle strobe when start is rejected.
- pulse_idx  out  8  index of current pulse in burst.
- burst_idx  out  16  index of current burst.

## Operation
- States: IDLE, PULSE_ON, PULSE_GAP, BURST_GAP, DONE.
- Config check on start in IDLE. Reject if any of:
  - pulse_width_us == 0
  - pulse_width_us >= pulse_period_us
  - pulses_per_burst == 0
  - bursts_per_train == 0
  - ch_sel == 0
  - bursts_per_train > 1 and pulses_per_burst × pulse_period_us > burst_period_us (32-bit unsigned compare)
- On reject: cfg_err for one cycle, stay IDLE, no register changes.
- On accept: latch all config, clear µs prescaler, pulse timer, burst timer and both indices, then go to PULSE_ON.
- PULSE_ON: igbt_on_en = ch_sel latched. When pulse timer reaches pulse_width_us, go to PULSE_GAP.
- PULSE_GAP, pulse timer reaches pulse_period_us:
  - If pulse_idx < pulses_per_burst−1: increment pulse_idx, clear pulse timer, go to PULSE_ON.
  - Otherwise, if burst_idx < bursts_per_train−1: go to BURST_GAP.
  - Otherwise: go to DONE.
- Last pulse of the train: PULSE_GAP is skipped. When its width expires, go directly to DONE.
- BURST_GAP: when burst timer reaches burst_period_us, increment burst_idx, clear pulse_idx and both timers, go to PULSE_ON.
- DONE: done = 1 for one cycle, then IDLE.
- stop (any non-IDLE state): next edge enters IDLE, igbt_on_en = 0, busy = 0, aborted = 1 for one cycle, no done.
- stop in IDLE has no effect. stop and start in the same IDLE cycle: stop wins, start ignored, no cfg_err.
- start while busy: ignored.

## Timing
- Reset values: igbt_on_en = 0, igbt_on_time = 0, busy = 0, done = 0, aborted = 0, cfg_err = 0, pulse_idx = 0, burst_idx = 0, state IDLE.
- µs tick: prescaler counts 0..CLK_PER_US−1. Tick is asserted on the count CLK_PER_US−1. Timers advance only on tick.
- Start accepted at edge T: igbt_on_en and busy are high from cycle T+1.
- Every pulse is high for exactly CLK_PER_US × pulse_width_us cycles.
- Start of pulse k in burst j: cycle T+1 + CLK_PER_US × (j × burst_period_us + k × pulse_period_us).
- done is asserted the cycle after the final pulse's igbt_on_en falls. busy falls with done.
- All outputs are registered. There is no combinational path from any input to any output.
- Pulse and burst timers are 24-bit and saturate at maximum. Config validation guarantees they never wrap.
- Reset mid-train: all outputs return to reset values on the next edge. No strobes are emitted.

## Structure
- Package tms_seq_pkg:
  - state enum
  - CLK_PER_US, N_CH
  - width constants US_W = 24, PCNT_W = 8, BCNT_W = 16
- Sub-module us_tick_gen: prescaler with sync clear, parameterized by CLK_PER_US, single tick output. The parent holds the FSM, timers, validation and output registers.

## Test plan
- width 3, period 10, pulses 4, bursts 1, ch_sel 5'b00001 -> four 150-cycle pulses starting at T+1, +500, +1000, +1500. done at T+1+1650. igbt_on_time = 3.
- pulses 2, period 5, width 2, bursts 3, burst_period 20, ch_sel 5'b10101 -> 6 pulses at µs offsets 0, 5, 20, 25, 40, 45, en = 5'b10101 during each. burst_idx reaches 2.
- width 10, period 10 -> cfg_err one cycle, busy stays 0. Also: pulses 3, period 10, burst_period 25, bursts 2 -> cfg_err.
- stop asserted mid PULSE_ON of pulse 2 -> en = 0 next cycle, aborted = 1, no done. A new start is accepted afterwards.
- sys_rst during BURST_GAP -> all outputs 0 next edge. start held during busy is ignored, verified by unchanged pulse timing.
- Simultaneous start and stop in IDLE -> no activity, no strobes.
